// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the serial subtractor. The controller side
// (master) issues start with operands; the subtractor side (slave)
// reports busy/done and the held result.
interface serial_subtractor_if
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout
   );

endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bin with borrow-out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference bit and borrow generated when x < y + bin
   always_comb begin
      d    = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
   end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop. The result
// is held on diff/bout from done until the next accepted start.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   serial_subtractor_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             borrow;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             last_bit;
   logic             cell_d;
   logic             cell_bo;

   // Start is honoured in IDLE and in the DONE cycle (back-to-back), never mid-shift
   assign accept   = bus.start && (state != ST_SHIFT);
   assign last_bit = (state == ST_SHIFT) && (cnt == CNT_W'(WIDTH - 1));

   full_subtractor u_cell (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .bin  (borrow),
      .d    (cell_d),
      .bout (cell_bo)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = accept ? ST_SHIFT : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Operand/result shift registers, borrow FF, bit counter and held outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else if (accept) begin
         a_sr   <= bus.a;
         b_sr   <= bus.b;
         borrow <= bus.bin;
         cnt    <= '0;
      end else if (state == ST_SHIFT) begin
         a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
         res_sr <= {cell_d, res_sr[WIDTH-1:1]};
         borrow <= cell_bo;
         cnt    <= cnt + CNT_W'(1);
         if (last_bit) begin
            diff_q <= {cell_d, res_sr[WIDTH-1:1]};
            bout_q <= cell_bo;
         end
      end
   end

   assign bus.busy = (state == ST_SHIFT);
   assign bus.done = (state == ST_DONE);
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;

endmodule : serial_subtractor
